wb_decode: RTL and testbench
============================

WB_DECODE -- requirements
Module: wb_decode

Interface
REQ-001 SHALL have parameter NSLV, default 6, giving the number of slave ports.
REQ-002 SHALL have parameter TIMEOUT, default 255, giving the maximum number of WAIT cycles before an error acknowledge.
REQ-003 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF, giving the read data returned on error.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port m_cyc_i / m_stb_i / m_we_i, input, 1 bit each: master cycle, strobe and write enable.
REQ-007 SHALL have port m_adr_i, input, 32 bits: master address; one-hot region bits [31:26].
REQ-008 SHALL have port m_ack_o, output, 1 bit: registered acknowledge to the master.
REQ-009 SHALL have port m_dat_o, output, 32 bits: registered read data to the master.
REQ-010 SHALL have port s_cyc_o, output, NSLV bits: per-slave cycle; at most one bit set.
REQ-011 SHALL have port s_stb_o, output, 1 bit: strobe, high only while some s_cyc_o bit is high.
REQ-012 SHALL have port s_ack_i, input, NSLV bits: per-slave acknowledge.
REQ-013 SHALL have port s_dat_i, input, 32*NSLV bits: flattened slave read data; slave i occupies [32i+31:32i].
REQ-014 SHALL have port err_o, output, 1 bit: sticky bus-error flag.
REQ-015 SHALL have port err_adr_o, output, 32 bits: address of the most recent errored access.
REQ-016 SHALL have port err_cnt_o, output, 8 bits: saturating error count.
REQ-017 SHALL have port err_clr_i, input, 1 bit: clears err_o and err_cnt_o.

Function
REQ-018 Slave index SHALL be decoded with adr[31] (idx 0, SPI RAM) at highest priority, down to adr[26] (idx 5, SPI) at lowest; a multi-bit address SHALL select the highest set bit.
REQ-019 The FSM SHALL have states IDLE, WAIT, ACK and ERR.
REQ-020 IDLE with m_cyc_i&m_stb_i and a decoded slave SHALL latch the index, load the timeout counter with TIMEOUT and go to WAIT; s_cyc_o[idx] SHALL rise the following cycle.
REQ-021 IDLE with m_cyc_i&m_stb_i and adr[31:26]==0 SHALL go to ERR with no s_cyc_o asserted.
REQ-022 In WAIT, s_ack_i[idx] SHALL register s_dat_i slice idx into m_dat_o, drop s_cyc_o and go to ACK.
REQ-023 ACK SHALL assert m_ack_o for exactly one cycle and then return to IDLE.
REQ-024 Latency: a slave ack in cycle k SHALL produce m_ack_o in cycle k+1.
REQ-025 In WAIT with no ack, the counter SHALL decrement each cycle; at zero the block SHALL drop s_cyc_o and go to ERR.
REQ-026 ERR SHALL pulse m_ack_o for one cycle with m_dat_o=ERR_DATA, set err_o, capture err_adr_o, increment err_cnt_o (saturating at 255), then go to IDLE.
REQ-027 Ack and counter reaching zero in the same cycle: ack SHALL win.
REQ-028 Acks from non-selected slaves SHALL be ignored at all times.
REQ-029 m_cyc_i low in WAIT SHALL abort: s_cyc_o cleared, no m_ack_o, go to IDLE, no error recorded.
REQ-030 err_clr_i SHALL take priority over a simultaneous error set and increment.
REQ-031 m_dat_o SHALL hold its value outside ACK/ERR.

Reset
REQ-032 rst SHALL force IDLE immediately, independent of clk.
REQ-033 Reset values SHALL be: s_cyc_o=0, s_stb_o=0, m_ack_o=0, m_dat_o=0, err_o=0, err_adr_o=0, err_cnt_o=0, counter=0.
REQ-034 Reset during WAIT SHALL drop s_cyc_o in the same cycle with no m_ack_o.

Structure
REQ-035 Package wb_pkg SHALL hold the region bit positions (31..26), slave index constants, the FSM state encoding and the ERR_DATA default.
REQ-036 The timeout down-counter SHALL be a sub-module wb_tmo_cnt with load, enable and zero outputs.

Verification
REQ-037 Read 0x10000004, GPIO acks 3 cycles after s_cyc_o with 0x0000000A -> s_cyc_o=6'b001000, m_ack_o 1 cycle later, m_dat_o=0x0000000A, err_o=0.
REQ-038 Access to 0x00000100 -> no s_cyc_o, m_ack_o after 1 cycle, m_dat_o=0xDEADBEEF, err_o=1, err_adr_o=0x00000100, err_cnt_o=1.
REQ-039 Silent slave on 0x20000000 with TIMEOUT=4 -> s_cyc_o held for 5 cycles, then error ack; ack arriving in the zero cycle -> normal ack instead.
REQ-040 Address 0xC0000000 -> only s_cyc_o[0]; a stray s_ack_i[1] is ignored.
REQ-041 m_cyc_i dropped mid-WAIT, and separately rst asserted mid-WAIT -> s_cyc_o=0 immediately, no m_ack_o, error state unchanged.
REQ-042 300 unmapped accesses -> err_cnt_o=255; err_clr_i coincident with an error -> err_o=0 and err_cnt_o=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and types for the Wishbone region decoder.
// Region bits [31:26] are one-hot; adr[31] maps to slave index 0.
package wb_pkg;
  localparam int REGION_HI = 31;
  localparam int REGION_LO = 26;
  localparam int NREGION   = REGION_HI - REGION_LO + 1;
  localparam int IDX_W     = 3;

  localparam logic [IDX_W-1:0] SLV_SPI_RAM = 3'd0;
  localparam logic [IDX_W-1:0] SLV_GPIO    = 3'd3;
  localparam logic [IDX_W-1:0] SLV_SPI     = 3'd5;
  localparam logic [IDX_W-1:0] SLV_NONE    = 3'd6;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  // ACK and ERR share bit 1, so the master acknowledge comes straight from a flop.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10,
    ST_ERR  = 2'b11
  } state_t;

  function automatic logic [IDX_W-1:0] region_idx(input logic [31:0] adr);
    logic [IDX_W-1:0] idx;
    casez (adr[REGION_HI -: NREGION])
      6'b1?????: idx = SLV_SPI_RAM;
      6'b01????: idx = 3'd1;
      6'b001???: idx = 3'd2;
      6'b0001??: idx = SLV_GPIO;
      6'b00001?: idx = 3'd4;
      6'b000001: idx = SLV_SPI;
      default:   idx = SLV_NONE;
    endcase
    return idx;
  endfunction
endpackage

// File: rtl/wb_tmo_cnt.sv
// Slave-response timeout down-counter.
// Load has priority over enable; the count holds once it reaches zero.
module wb_tmo_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);
  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/wb_decode.sv
// Wishbone address decoder: one-hot region select, slave timeout and
// bus-error reporting (sticky flag, last errored address, saturating count).
module wb_decode
  import wb_pkg::*;
#(
  parameter int          NSLV     = 6,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m_cyc_i,
  input  logic                 m_stb_i,
  input  logic                 m_we_i,
  input  logic [31:0]          m_adr_i,
  output logic                 m_ack_o,
  output logic [31:0]          m_dat_o,
  output logic [NSLV-1:0]      s_cyc_o,
  output logic                 s_stb_o,
  input  logic [NSLV-1:0]      s_ack_i,
  input  logic [32*NSLV-1:0]   s_dat_i,
  output logic                 err_o,
  output logic [31:0]          err_adr_o,
  output logic [7:0]           err_cnt_o,
  input  logic                 err_clr_i
);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx_q, ridx;
  logic [31:0]      adr_q;
  logic [31:0]      sel_dat;
  logic             req, hit, sel_ack;
  logic             tmo_load, tmo_en, tmo_zero, enter_err;
  logic             unused_we;

  // Reads and writes decode identically; the direction is only passed through.
  assign unused_we = m_we_i;

  assign req  = m_cyc_i & m_stb_i;
  assign ridx = region_idx(m_adr_i);
  assign hit  = (ridx != SLV_NONE) && (int'(ridx) < NSLV);

  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_ack = s_ack_i[i];
        sel_dat = s_dat_i[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Master abort beats ack, and ack beats the timeout expiring.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req) state_nxt = hit ? ST_WAIT : ST_ERR;
      ST_WAIT: begin
        if (!m_cyc_i)      state_nxt = ST_IDLE;
        else if (sel_ack)  state_nxt = ST_ACK;
        else if (tmo_zero) state_nxt = ST_ERR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o = '0;
    m_ack_o = 1'b0;
    case (state)
      ST_WAIT: begin
        for (int i = 0; i < NSLV; i++) begin
          s_cyc_o[i] = m_cyc_i && (idx_q == IDX_W'(i));
        end
      end
      ST_ACK, ST_ERR: m_ack_o = 1'b1;
      default: ;
    endcase
  end

  assign s_stb_o = |s_cyc_o;

  assign tmo_load  = (state == ST_IDLE) && req && hit;
  assign tmo_en    = (state == ST_WAIT);
  assign enter_err = (state != ST_ERR) && (state_nxt == ST_ERR);

  wb_tmo_cnt #(.WIDTH(TW)) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .load     (tmo_load),
    .en       (tmo_en),
    .load_val (TW'(TIMEOUT)),
    .zero     (tmo_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      adr_q <= '0;
    end else if ((state == ST_IDLE) && req) begin
      idx_q <= ridx;
      adr_q <= m_adr_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_dat_o <= '0;
    end else if (state_nxt == ST_ACK) begin
      m_dat_o <= sel_dat;
    end else if (enter_err) begin
      m_dat_o <= ERR_DATA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_o     <= 1'b0;
      err_adr_o <= '0;
      err_cnt_o <= '0;
    end else begin
      if (enter_err) begin
        err_adr_o <= (state == ST_IDLE) ? m_adr_i : adr_q;
      end
      if (err_clr_i) begin
        err_o     <= 1'b0;
        err_cnt_o <= '0;
      end else if (enter_err) begin
        err_o <= 1'b1;
        if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_wb_decode.sv
// Bench for wb_decode: each transaction's timeline (slave select window, ack
// cycle, returned data, error bookkeeping) is predicted from the decode rules.
module tb_wb_decode;
  localparam int          NSLV = 6;
  localparam int          TMO  = 4;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic                clk = 1'b0;
  logic                rst;
  logic                m_cyc_i, m_stb_i, m_we_i;
  logic [31:0]         m_adr_i;
  logic                m_ack_o;
  logic [31:0]         m_dat_o;
  logic [NSLV-1:0]     s_cyc_o;
  logic                s_stb_o;
  logic [NSLV-1:0]     s_ack_i;
  logic [32*NSLV-1:0]  s_dat_i;
  logic                err_o;
  logic [31:0]         err_adr_o;
  logic [7:0]          err_cnt_o;
  logic                err_clr_i;

  int n_chk = 0;
  int n_fail = 0;

  logic        ref_err;
  logic [31:0] ref_adr;
  int          ref_cnt;
  logic [31:0] ref_dat;

  always #5 clk = ~clk;

  wb_decode #(.NSLV(NSLV), .TIMEOUT(TMO), .ERR_DATA(ERRD)) dut (
    .clk       (clk),
    .rst       (rst),
    .m_cyc_i   (m_cyc_i),
    .m_stb_i   (m_stb_i),
    .m_we_i    (m_we_i),
    .m_adr_i   (m_adr_i),
    .m_ack_o   (m_ack_o),
    .m_dat_o   (m_dat_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_ack_i   (s_ack_i),
    .s_dat_i   (s_dat_i),
    .err_o     (err_o),
    .err_adr_o (err_adr_o),
    .err_cnt_o (err_cnt_o),
    .err_clr_i (err_clr_i)
  );

  // Highest set bit of adr[31:26] at position p selects slave 5-p; none -> -1.
  function automatic int exp_slave(input logic [31:0] adr);
    int top;
    top = int'(adr[31:26]);
    if (top == 0) return -1;
    return 5 - ($clog2(top + 1) - 1);
  endfunction

  // Random acks/data on every slave; the selected slave only acks when told to.
  task automatic drive_slaves(input int sel, input bit ack_sel, input logic [31:0] dat,
                              input bit force_stray);
    logic [NSLV-1:0] m;
    m = NSLV'($urandom);
    if (force_stray) m = '1;
    for (int i = 0; i < NSLV; i++) s_dat_i[32*i +: 32] = $urandom;
    if (sel >= 0) begin
      m[sel] = ack_sel;
      if (ack_sel) s_dat_i[32*sel +: 32] = dat;
    end
    s_ack_i = m;
  endtask

  // dly: cycles after s_cyc_o rises before the slave acks; negative means never.
  task automatic run_xact(input logic [31:0] adr, input int dly, input logic [31:0] dat,
                          input bit force_stray, input string tag);
    int              sel, cyc_exp;
    bit              is_err;
    logic [NSLV-1:0] oh, exp_cyc;
    logic [31:0]     dexp;
    sel = exp_slave(adr);
    oh = '0;
    if (sel >= 0) oh[sel] = 1'b1;
    is_err  = (sel < 0) || (dly < 0) || (dly > TMO);
    cyc_exp = (sel < 0) ? 0 : (is_err ? TMO + 1 : dly + 1);
    dexp    = is_err ? ERRD : dat;
    @(negedge clk);
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'($urandom); m_adr_i = adr;
    drive_slaves(sel, 1'b0, '0, force_stray);
    for (int c = 1; c <= cyc_exp + 2; c++) begin
      @(negedge clk);
      if (c == cyc_exp + 1) begin
        ref_dat = dexp;
        if (is_err) begin
          ref_err = 1'b1;
          ref_adr = adr;
          if (ref_cnt < 255) ref_cnt++;
        end
      end
      exp_cyc = (c <= cyc_exp) ? oh : '0;
      n_chk++;
      if (s_cyc_o !== exp_cyc) begin
        n_fail++;
        $display("FAIL %s s_cyc_o cyc%0d adr=%h: got %b exp %b", tag, c, adr, s_cyc_o, exp_cyc);
      end
      n_chk++;
      if (s_stb_o !== (|exp_cyc)) begin
        n_fail++;
        $display("FAIL %s s_stb_o cyc%0d: got %b exp %b", tag, c, s_stb_o, |exp_cyc);
      end
      n_chk++;
      if (m_ack_o !== (c == cyc_exp + 1)) begin
        n_fail++;
        $display("FAIL %s m_ack_o cyc%0d adr=%h dly=%0d: got %b exp %b", tag, c, adr, dly,
                 m_ack_o, (c == cyc_exp + 1));
      end
      n_chk++;
      if (m_dat_o !== ref_dat) begin
        n_fail++;
        $display("FAIL %s m_dat_o cyc%0d: got %h exp %h", tag, c, m_dat_o, ref_dat);
      end
      n_chk++;
      if ({err_o, err_adr_o, err_cnt_o} !== {ref_err, ref_adr, 8'(ref_cnt)}) begin
        n_fail++;
        $display("FAIL %s err_state cyc%0d: got %b/%h/%0d exp %b/%h/%0d", tag, c,
                 err_o, err_adr_o, err_cnt_o, ref_err, ref_adr, ref_cnt);
      end
      if (c == cyc_exp + 1) begin
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
      end
      drive_slaves(sel, (c == dly + 1), dat, force_stray);
    end
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if ({m_ack_o, s_stb_o, s_cyc_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ack=%b stb=%b cyc=%b exp all 0", m_ack_o, s_stb_o, s_cyc_o);
    end
    n_chk++;
    if (m_dat_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_dat: got %h exp 0", m_dat_o);
    end
    n_chk++;
    if ({err_o, err_adr_o, err_cnt_o} !== 41'h0) begin
      n_fail++;
      $display("FAIL reset_err: got %b/%h/%0d exp 0/0/0", err_o, err_adr_o, err_cnt_o);
    end
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h1000_0000;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({m_ack_o, s_cyc_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got ack=%b cyc=%b exp 0", m_ack_o, s_cyc_o);
    end
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({m_ack_o, s_cyc_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got ack=%b cyc=%b exp 0", m_ack_o, s_cyc_o);
    end
  endtask

  task automatic test_gpio_read();
    run_xact(32'h1000_0004, 3, 32'h0000_000A, 1'b0, "gpio_read");
    n_chk++;
    if ({m_dat_o, err_o} !== {32'h0000_000A, 1'b0}) begin
      n_fail++;
      $display("FAIL gpio_result: got dat=%h err=%b exp 0000000a/0", m_dat_o, err_o);
    end
  endtask

  task automatic test_unmapped();
    run_xact(32'h0000_0100, -1, '0, 1'b0, "unmapped");
    n_chk++;
    if ({m_dat_o, err_o, err_adr_o, err_cnt_o} !== {ERRD, 1'b1, 32'h0000_0100, 8'd1}) begin
      n_fail++;
      $display("FAIL unmapped_result: got %h/%b/%h/%0d exp deadbeef/1/00000100/1",
               m_dat_o, err_o, err_adr_o, err_cnt_o);
    end
  endtask

  task automatic test_timeout();
    run_xact(32'h2000_0000, -1, '0, 1'b0, "timeout_silent");
    run_xact(32'h2000_0000, TMO, 32'h1234_5678, 1'b0, "ack_at_zero");
    run_xact(32'h2000_0000, TMO - 1, 32'h0BAD_F00D, 1'b0, "ack_before_zero");
    run_xact(32'h2000_0000, TMO + 1, 32'h5555_AAAA, 1'b0, "ack_too_late");
  endtask

  task automatic test_priority();
    run_xact(32'hC000_0000, 2, 32'hCAFE_F00D, 1'b1, "multi_bit_stray");
    run_xact(32'h0C00_0000, 1, 32'h0000_0042, 1'b1, "low_pair_stray");
  endtask

  task automatic test_abort_cyc();
    @(negedge clk);
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h0400_0000;
    drive_slaves(5, 1'b0, '0, 1'b0);
    @(negedge clk);
    drive_slaves(5, 1'b0, '0, 1'b0);
    @(negedge clk);
    n_chk++;
    if (s_cyc_o !== 6'b100000) begin
      n_fail++;
      $display("FAIL abort_pre: got %b exp 100000", s_cyc_o);
    end
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    #1;
    n_chk++;
    if ({s_cyc_o, s_stb_o, m_ack_o} !== '0) begin
      n_fail++;
      $display("FAIL abort_drop: got cyc=%b stb=%b ack=%b exp 0", s_cyc_o, s_stb_o, m_ack_o);
    end
    for (int c = 0; c < TMO + 3; c++) begin
      @(negedge clk);
      n_chk++;
      if ({m_ack_o, s_cyc_o, m_dat_o, err_o, err_adr_o, err_cnt_o} !==
          {1'b0, 6'b0, ref_dat, ref_err, ref_adr, 8'(ref_cnt)}) begin
        n_fail++;
        $display("FAIL abort_after cyc%0d: got ack=%b cyc=%b dat=%h err=%b/%h/%0d", c,
                 m_ack_o, s_cyc_o, m_dat_o, err_o, err_adr_o, err_cnt_o);
      end
    end
    run_xact(32'h0400_0000, 0, 32'h7777_0001, 1'b0, "after_abort");
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h0800_0010;
    drive_slaves(4, 1'b0, '0, 1'b0);
    @(negedge clk);
    drive_slaves(4, 1'b0, '0, 1'b0);
    n_chk++;
    if (s_cyc_o !== 6'b010000) begin
      n_fail++;
      $display("FAIL rstwait_pre: got %b exp 010000", s_cyc_o);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({s_cyc_o, s_stb_o, m_ack_o} !== '0) begin
      n_fail++;
      $display("FAIL rstwait_drop: got cyc=%b stb=%b ack=%b exp 0", s_cyc_o, s_stb_o, m_ack_o);
    end
    n_chk++;
    if ({m_dat_o, err_o, err_adr_o, err_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL rstwait_regs: got dat=%h err=%b/%h/%0d exp 0", m_dat_o, err_o,
               err_adr_o, err_cnt_o);
    end
    ref_err = 1'b0; ref_adr = '0; ref_cnt = 0; ref_dat = '0;
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({m_ack_o, s_cyc_o} !== '0) begin
      n_fail++;
      $display("FAIL rstwait_after: got ack=%b cyc=%b exp 0", m_ack_o, s_cyc_o);
    end
  endtask

  task automatic test_random();
    logic [5:0]  top;
    logic [31:0] adr;
    int          dly;
    for (int n = 0; n < 60; n++) begin
      top = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      adr = {top, 26'($urandom)};
      dly = $urandom_range(0, TMO + 3);
      if (dly == TMO + 3) dly = -1;
      run_xact(adr, dly, $urandom, 1'($urandom), "random");
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 300; n++) begin
      run_xact({6'b0, 26'($urandom)}, -1, '0, 1'b0, "saturate");
    end
    n_chk++;
    if (err_cnt_o !== 8'd255) begin
      n_fail++;
      $display("FAIL saturate_final: got %0d exp 255", err_cnt_o);
    end
  endtask

  task automatic test_clr_coincident();
    @(negedge clk);
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h0000_0040; err_clr_i = 1'b1;
    drive_slaves(-1, 1'b0, '0, 1'b0);
    @(negedge clk);
    err_clr_i = 1'b0;
    ref_err = 1'b0; ref_cnt = 0; ref_adr = 32'h0000_0040; ref_dat = ERRD;
    n_chk++;
    if ({m_ack_o, m_dat_o} !== {1'b1, ERRD}) begin
      n_fail++;
      $display("FAIL clr_ack: got ack=%b dat=%h exp 1/deadbeef", m_ack_o, m_dat_o);
    end
    n_chk++;
    if ({err_o, err_cnt_o, err_adr_o} !== {1'b0, 8'd0, 32'h0000_0040}) begin
      n_fail++;
      $display("FAIL clr_priority: got err=%b cnt=%0d adr=%h exp 0/0/00000040",
               err_o, err_cnt_o, err_adr_o);
    end
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(negedge clk);
    n_chk++;
    if (m_ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_pulse: got ack=%b exp 0", m_ack_o);
    end
    run_xact(32'h0000_0080, -1, '0, 1'b0, "after_clr");
  endtask

  initial begin
    rst = 1'b1;
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0; m_adr_i = '0;
    s_ack_i = '0; s_dat_i = '0; err_clr_i = 1'b0;
    ref_err = 1'b0; ref_adr = '0; ref_cnt = 0; ref_dat = '0;
    test_reset();
    test_gpio_read();
    test_unmapped();
    test_timeout();
    test_priority();
    test_abort_cyc();
    test_reset_mid_wait();
    test_random();
    test_saturation();
    test_clr_coincident();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
